dest_reg_tracker: RTL and testbench
===================================

Name: dest_reg_tracker

Overview:
- Pipeline-register chain carrying each instruction's destination-register number and write/load flags from ID through EX, MEM and WB.
- Drives the MEM-stage and WB-stage destination numbers consumed by the EX-stage forwarding selector.
- Also detects load-use hazards: it issues a one-cycle ID stall and inserts an EX bubble.
- Sits beside the ID/EX, EX/MEM and MEM/WB data registers and shares their stall, flush and hold timing.

Parameters:
- REG_AW, 5, register-number width.
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hold  input  1  global freeze (memory busy); no tracker register updates while high.
- flush_ex  input  1  branch/jump taken; the instruction leaving ID is discarded.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_AW  ID source register rs.
- id_rt  input  REG_AW  ID source register rt.
- id_rs_used  input  1  instruction reads rs.
- id_rt_used  input  1  instruction reads rt.
- id_rd  input  REG_AW  resolved destination (rd or rt, already muxed).
- id_regwrite  input  1  instruction writes the register file.
- id_memread  input  1  instruction is a load.
- ex_rd  output  REG_AW  EX-stage destination.
- mem_rd  output  REG_AW  MEM-stage destination (forwarding "ddrw").
- wb_rd  output  REG_AW  WB-stage destination (forwarding "dddrw").
- ex_we, mem_we, wb_we  output  1 each  stage will write the register file.
- load_use_stall  output  1  combinational; ID/PC must hold this cycle.
- stall_cnt  output  CNT_W  count of cycles in which a load-use stall was issued.

Behaviour:
- Reset (async, rst_n=0):
  - all *_rd = 0 and all *_we = 0.
  - internal ex_memread = 0; stall_cnt = 0.
  - load_use_stall therefore evaluates to 0.
- Stage entry rule: a stage whose we=0 must present rd=0. A bubble always carries rd=0, we=0, memread=0.
- Write qualification:
  - ID entry qualified: we_in = id_valid & id_regwrite & (id_rd != 0).
  - Writes to $0 are treated as no-write and enter as rd=0, we=0.
- load_use_stall = ex_memread & ex_we & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)) & id_valid.
- Per rising edge, hold=0, in priority order:
  - flush_ex=1: EX receives a bubble. This holds even if load_use_stall=1, because flush dominates stall.
  - else load_use_stall=1: EX receives a bubble; the ID instruction is re-presented next cycle by upstream.
  - else: EX receives the ID fields.
  - MEM takes the EX fields and WB takes the MEM fields unconditionally; stall and flush never affect MEM or WB.
- hold=1:
  - no register changes, stall_cnt included.
  - load_use_stall is still driven combinationally from the current state.
- Latency: an instruction's destination appears on ex_rd 1 cycle after it is accepted from ID, on mem_rd 2 cycles after, and on wb_rd 3 cycles after.
- A load-use pair costs exactly one stall cycle. After the bubble, the load is in MEM, and forwarding from mem_rd/WB resolves the hazard.
- stall_cnt increments on each edge with hold=0, load_use_stall=1 and flush_ex=0. It saturates at all-ones and never wraps.
- Reset mid-operation clears every stage immediately, with no clock needed. The first edge after deassertion behaves as a normal edge.

Test Plan:
- Reset then three ALU instructions with rd=3, 4, 5 on consecutive cycles, regwrite=1 -> at cycle 3: wb_rd=3, mem_rd=4, ex_rd=5, all we=1, load_use_stall=0.
- Load rd=8, then consumer with rt=8, rt_used=1 -> load_use_stall=1 for exactly 1 cycle; next cycle ex_rd=0, ex_we=0, mem_rd=8; stall_cnt=1.
- Load rd=8, then consumer with rt=8 and flush_ex=1 in the same cycle -> EX bubble; stall_cnt stays 0; next-cycle load_use_stall=0 (load now in MEM).
- Instruction with rd=0, regwrite=1 -> ex_rd=0, ex_we=0; a following load to $0 with consumer rs=0 produces no stall.
- hold=1 for 4 cycles during a load-use hazard -> all *_rd and stall_cnt frozen, load_use_stall stays 1; the first edge after hold=0 inserts the bubble and stall_cnt=1.
- Preload stall_cnt near saturation (CNT_W=4 build, 15 stalls) plus 2 more stalls -> stall_cnt=15. Assert rst_n low mid-sequence -> all outputs 0 immediately, before any clock edge.

Source files
------------

// File: rtl/dest_reg_tracker.sv
// Destination-register pipeline chain (ID->EX->MEM->WB) feeding the EX forwarding
// selector, with load-use hazard detection and a saturating stall-event counter.
module dest_reg_tracker #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush_ex,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              ex_we,
  output logic              mem_we,
  output logic              wb_we,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic ex_memread;
  logic we_in;
  logic ex_bubble;

  // Writes to $0 are dropped at entry so forwarding never matches register zero.
  assign we_in = id_valid & id_regwrite & (id_rd != '0);

  assign load_use_stall = ex_memread & ex_we & id_valid &
                          ((id_rs_used & (id_rs == ex_rd)) |
                           (id_rt_used & (id_rt == ex_rd)));

  // Flush dominates stall: both turn the EX entry into a bubble.
  assign ex_bubble = flush_ex | load_use_stall;

  // NOTE: state registers use non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd      <= '0;
      ex_we      <= 1'b0;
      ex_memread <= 1'b0;
      mem_rd     <= '0;
      mem_we     <= 1'b0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
      stall_cnt  <= '0;
    end else if (!hold) begin
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      if (ex_bubble) begin
        ex_rd      <= '0;
        ex_we      <= 1'b0;
        ex_memread <= 1'b0;
      end else begin
        ex_rd      <= we_in ? id_rd : '0;
        ex_we      <= we_in;
        ex_memread <= we_in & id_memread;
      end
      if (load_use_stall && !flush_ex && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Self-checking bench for dest_reg_tracker: directed scenarios followed by random
// traffic, all compared against a stage-list reference model.
module tb_dest_reg_tracker;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic          flush_ex = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs = '0;
  logic [AW-1:0] id_rt = '0;
  logic          id_rs_used = 1'b0;
  logic          id_rt_used = 1'b0;
  logic [AW-1:0] id_rd = '0;
  logic          id_regwrite = 1'b0;
  logic          id_memread = 1'b0;

  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic          ex_we, mem_we, wb_we, load_use_stall;
  logic [15:0]   stall_cnt;

  logic [AW-1:0] s_ex_rd, s_mem_rd, s_wb_rd;
  logic          s_ex_we, s_mem_we, s_wb_we, s_lus;
  logic [3:0]    s_stall_cnt;

  dest_reg_tracker dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush_ex(flush_ex),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .load_use_stall(load_use_stall), .stall_cnt(stall_cnt)
  );

  // Narrow-counter build sharing the same stimulus, used for saturation.
  dest_reg_tracker #(.REG_AW(AW), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush_ex(flush_ex),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_rd(s_ex_rd), .mem_rd(s_mem_rd), .wb_rd(s_wb_rd),
    .ex_we(s_ex_we), .mem_we(s_mem_we), .wb_we(s_wb_we),
    .load_use_stall(s_lus), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd;
    bit we;
    bit load;
  } instr_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t pipe[3];
  int     stalls;
  int     checks = 0;
  int     failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.rd = 0; b.we = 0; b.load = 0;
    return b;
  endfunction

  function automatic bit model_hazard();
    if (!(pipe[0].load && pipe[0].we && id_valid)) return 0;
    return (id_rs_used && int'(id_rs) == pipe[0].rd) ||
           (id_rt_used && int'(id_rt) == pipe[0].rd);
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    stalls = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ex_rd"},  32'(ex_rd),  32'(pipe[0].rd));
    check({tag, ".ex_we"},  32'(ex_we),  32'(pipe[0].we));
    check({tag, ".mem_rd"}, 32'(mem_rd), 32'(pipe[1].rd));
    check({tag, ".mem_we"}, 32'(mem_we), 32'(pipe[1].we));
    check({tag, ".wb_rd"},  32'(wb_rd),  32'(pipe[2].rd));
    check({tag, ".wb_we"},  32'(wb_we),  32'(pipe[2].we));
    check({tag, ".cnt"},    32'(stall_cnt),   32'(sat(stalls, 65535)));
    check({tag, ".cnt4"},   32'(s_stall_cnt), 32'(sat(stalls, 15)));
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                       input int rd, input bit rw, input bit mr, input bit fl, input bit hd);
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_rs_used = rsu; id_rt_used = rtu;
    id_rd = AW'(rd); id_regwrite = rw; id_memread = mr; flush_ex = fl; hold = hd;
  endtask

  // One clock: check the combinational stall, advance the model, check the stages.
  task automatic step(input string tag);
    bit     haz;
    instr_t nxt;
    #1;
    haz = model_hazard();
    check({tag, ".lus"},  32'(load_use_stall), 32'(haz));
    check({tag, ".lus4"}, 32'(s_lus), 32'(haz));
    @(posedge clk);
    if (!hold) begin
      nxt.we   = id_valid && id_regwrite && (id_rd != 0);
      nxt.rd   = nxt.we ? int'(id_rd) : 0;
      nxt.load = id_valid && id_memread;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (flush_ex || haz) ? bubble() : nxt;
      if (haz && !flush_ex) stalls++;
    end
    #1;
    check_state(tag);
  endtask

  task automatic nop(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_state("reset");
    check("reset.lus", 32'(load_use_stall), 32'(0));
    rst_n = 1'b1;

    // Three back-to-back ALU writes
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0); step("alu3");
    drive(1, 1, 2, 1, 1, 4, 1, 0, 0, 0); step("alu4");
    drive(1, 1, 2, 1, 1, 5, 1, 0, 0, 0); step("alu5");
    check("alu.wb_rd", 32'(wb_rd), 32'd3);
    check("alu.mem_rd", 32'(mem_rd), 32'd4);
    check("alu.ex_rd", 32'(ex_rd), 32'd5);
    check("alu.we", 32'({ex_we, mem_we, wb_we}), 32'h7);
    nop("nop0"); nop("nop1");

    // Load-use pair costs one stall
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); step("ld8");
    drive(1, 1, 8, 0, 1, 9, 1, 0, 0, 0);
    #1 check("lu.stall_on", 32'(load_use_stall), 32'd1);
    step("lu_stall");
    check("lu.bubble", 32'({ex_rd, ex_we}), 32'd0);
    check("lu.mem_rd", 32'(mem_rd), 32'd8);
    check("lu.cnt", 32'(stall_cnt), 32'd1);
    step("lu_retry");
    check("lu.retry_ex", 32'(ex_rd), 32'd9);
    nop("nop2"); nop("nop3");

    // Flush dominates a concurrent stall
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); step("ld8f");
    drive(1, 1, 8, 0, 1, 9, 1, 0, 1, 0); step("flush");
    check("flush.cnt", 32'(stall_cnt), 32'd1);
    drive(1, 1, 8, 0, 1, 9, 1, 0, 0, 0); step("post_flush");
    nop("nop4"); nop("nop5");

    // Writes and loads to $0
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); step("rd0");
    check("rd0.ex", 32'({ex_rd, ex_we}), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); step("ld0");
    drive(1, 0, 0, 1, 0, 7, 1, 0, 0, 0); step("use0");
    nop("nop6"); nop("nop7");

    // Hold across a pending load-use hazard
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); step("ldh");
    for (int i = 0; i < 4; i++) begin
      drive(1, 8, 0, 1, 0, 10, 1, 0, 0, 1); step("hold");
    end
    drive(1, 8, 0, 1, 0, 10, 1, 0, 0, 0); step("hold_rel");
    check("hold.bubble", 32'(ex_we), 32'd0);
    check("hold.cnt", 32'(stall_cnt), 32'd2);
    step("hold_retry");
    nop("nop8"); nop("nop9");

    // Drive the narrow counter into saturation
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); step("sat_ld");
      drive(1, 8, 8, 1, 1, 11, 1, 0, 0, 0); step("sat_stall");
      step("sat_retry");
    end
    check("sat.cnt4", 32'(s_stall_cnt), 32'd15);

    // Random traffic with a small register space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      step("rand");
    end

    // Asynchronous reset mid-sequence, between clock edges
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); step("pre_rst");
    drive(1, 8, 0, 1, 0, 12, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    check("async_rst.lus", 32'(load_use_stall), 32'd0);
    #2 rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); step("post_rst");
    check("post_rst.ex_rd", 32'(ex_rd), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
